// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multicycle MIPS control unit:
//                opcode/funct values, controller state encoding, ALU
//                control codes, ALUOp codes and an opcode legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp: what the ALU decoder should derive the operation from
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        IMMEXEC = 4'd8,
        IMMWB   = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // True when the opcode belongs to the optional extension set
    function automatic logic is_ext_opcode(input logic [5:0] op);
        return (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational ALU decoder. Maps ALUOp plus opcode/funct to
//                the 3-bit ALU control and flags unsupported R-type funct.
//  Revision    : 1.0 - initial release
//  Ports       : alu_op      in  2  operation source select
//                opcode      in  6  instruction opcode
//                funct       in  6  instruction funct field
//                alu_control out 3  ALU operation
//                bad_funct   out 1  funct not supported (ALUOp=funct only)
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    // Unknown funct keeps the harmless add encoding
                    default: bad_funct   = 1'b1;
                endcase
            end
            ALUOP_LOGIC: begin
                // Logical immediates pick and/or; addi falls back to add
                case (opcode)
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Control FSM for the multicycle MIPS core. Steps each
//                instruction through fetch/decode/execute/memory/writeback,
//                stalls on the memory ready handshake and optionally aborts a
//                stalled access after TIMEOUT_CYCLES wait cycles.
//  Revision    : 1.0 - initial release
//  Parameters  : EXT_OPS        - nonzero enables bne/andi/ori
//                TIMEOUT_CYCLES - memory wait limit, 0 disables the timeout
//  Ports       : clk, rst_n (async active-low)
//                opcode, funct, alu_zero, mem_ready        - inputs
//                mem_req, mem_write, iord, ir_write, pc_en - memory/PC/IR
//                pc_src, alu_src_a, alu_src_b, zero_ext,
//                alu_control                                - datapath muxes
//                reg_dst, mem_to_reg, reg_write             - register file
//                illegal_op, mem_err                        - status pulses
// ============================================================================
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int EXT_OPS        = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam bit EXT_EN = (EXT_OPS != 0);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] w_alu_op;
    logic       w_bad_funct;
    logic       w_wait_state;
    logic       w_timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // ALUOp depends on state only, kept apart from the main decode so the
    // decoder's bad_funct output does not feed back into its own source.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (state_q)
            EXECUTE: w_alu_op = ALUOP_FUNCT;
            IMMEXEC: w_alu_op = ALUOP_LOGIC;
            BRANCH:  w_alu_op = ALUOP_SUB;
            default: w_alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (alu_control),
        .bad_funct   (w_bad_funct)
    );

    // States that stall on the memory handshake
    assign w_wait_state = (state_q == FETCH) || (state_q == MEMRD) ||
                          (state_q == MEMWR);

    // ------------------------------------------------------------------
    // Memory wait timeout
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            // A stalled wait state is the only way to keep the state
            // unchanged with mem_ready low, so anything else clears it.
            always_comb begin
                count_d = '0;
                if (w_wait_state && !mem_ready && !w_timeout) begin
                    count_d = count_q + 1'b1;
                end
            end

            assign w_timeout = w_wait_state && !mem_ready &&
                               (count_q == CNT_W'(TIMEOUT_CYCLES));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_ADDI:      state_d = IMMEXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ANDI, OP_ORI, OP_BNE: begin
                        if (EXT_EN) begin
                            state_d = (opcode == OP_BNE) ? BRANCH : IMMEXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                if (w_bad_funct) begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = ALUWB;
                end
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zero_ext  = is_ext_opcode(opcode) && (opcode != OP_BNE);
                state_d   = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_en     = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Timed-out access is abandoned without side effects
        if (w_timeout) begin
            mem_err   = 1'b1;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            state_d   = FETCH;
        end

        // Reset must silence enables immediately, not on the next edge
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
        end
    end

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench. Two controllers share the
//                stimulus: dut_a (EXT_OPS=0, no timeout) and dut_b
//                (EXT_OPS=1, TIMEOUT_CYCLES=4). Each cycle the full control
//                word of both is compared with a hand-derived constant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    // Control word layout:
    // {mem_req, mem_write, iord, ir_write, pc_en, pc_src[1:0], alu_src_a,
    //  alu_src_b[1:0], zero_ext, alu_control[2:0], reg_dst, mem_to_reg,
    //  reg_write, illegal_op, mem_err}
    localparam logic [18:0] W_RST        = 19'b0_0_0_0_0_00_0_01_0_010_0_0_0_0_0;
    localparam logic [18:0] W_FETCH_RDY  = 19'b1_0_0_1_1_00_0_01_0_010_0_0_0_0_0;
    localparam logic [18:0] W_FETCH_WAIT = 19'b1_0_0_0_0_00_0_01_0_010_0_0_0_0_0;
    localparam logic [18:0] W_FETCH_TO   = 19'b1_0_0_0_0_00_0_01_0_010_0_0_0_0_1;
    localparam logic [18:0] W_DECODE     = 19'b0_0_0_0_0_00_0_11_0_010_0_0_0_0_0;
    localparam logic [18:0] W_DECODE_ILL = 19'b0_0_0_0_0_00_0_11_0_010_0_0_0_1_0;
    localparam logic [18:0] W_MEMADR     = 19'b0_0_0_0_0_00_1_10_0_010_0_0_0_0_0;
    localparam logic [18:0] W_MEMRD      = 19'b1_0_1_0_0_00_0_00_0_010_0_0_0_0_0;
    localparam logic [18:0] W_MEMWB      = 19'b0_0_0_0_0_00_0_00_0_010_0_1_1_0_0;
    localparam logic [18:0] W_MEMWR      = 19'b1_1_1_0_0_00_0_00_0_010_0_0_0_0_0;
    localparam logic [18:0] W_EXEC_SLT   = 19'b0_0_0_0_0_00_1_00_0_111_0_0_0_0_0;
    localparam logic [18:0] W_EXEC_BAD   = 19'b0_0_0_0_0_00_1_00_0_010_0_0_0_1_0;
    localparam logic [18:0] W_ALUWB      = 19'b0_0_0_0_0_00_0_00_0_010_1_0_1_0_0;
    localparam logic [18:0] W_IMM_ADDI   = 19'b0_0_0_0_0_00_1_10_0_010_0_0_0_0_0;
    localparam logic [18:0] W_IMM_ORI    = 19'b0_0_0_0_0_00_1_10_1_001_0_0_0_0_0;
    localparam logic [18:0] W_IMM_ANDI   = 19'b0_0_0_0_0_00_1_10_1_000_0_0_0_0_0;
    localparam logic [18:0] W_IMMWB      = 19'b0_0_0_0_0_00_0_00_0_010_0_0_1_0_0;
    localparam logic [18:0] W_BR_TAKEN   = 19'b0_0_0_0_1_01_1_00_0_110_0_0_0_0_0;
    localparam logic [18:0] W_BR_NOT     = 19'b0_0_0_0_0_01_1_00_0_110_0_0_0_0_0;
    localparam logic [18:0] W_JUMP       = 19'b0_0_0_0_1_10_0_00_0_010_0_0_0_0_0;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;

    logic       a_mem_req, a_mem_write, a_iord, a_ir_write, a_pc_en;
    logic [1:0] a_pc_src, a_alu_src_b;
    logic       a_alu_src_a, a_zero_ext, a_reg_dst, a_mem_to_reg, a_reg_write;
    logic       a_illegal_op, a_mem_err;
    logic [2:0] a_alu_control;

    logic       b_mem_req, b_mem_write, b_iord, b_ir_write, b_pc_en;
    logic [1:0] b_pc_src, b_alu_src_b;
    logic       b_alu_src_a, b_zero_ext, b_reg_dst, b_mem_to_reg, b_reg_write;
    logic       b_illegal_op, b_mem_err;
    logic [2:0] b_alu_control;

    logic [18:0] word_a;
    logic [18:0] word_b;

    int n_cmp;
    int n_err;

    multicycle_controller #(.EXT_OPS(0), .TIMEOUT_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .iord(a_iord),
        .ir_write(a_ir_write), .pc_en(a_pc_en), .pc_src(a_pc_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .zero_ext(a_zero_ext), .alu_control(a_alu_control),
        .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .reg_write(a_reg_write), .illegal_op(a_illegal_op),
        .mem_err(a_mem_err)
    );

    multicycle_controller #(.EXT_OPS(1), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .iord(b_iord),
        .ir_write(b_ir_write), .pc_en(b_pc_en), .pc_src(b_pc_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .zero_ext(b_zero_ext), .alu_control(b_alu_control),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .reg_write(b_reg_write), .illegal_op(b_illegal_op),
        .mem_err(b_mem_err)
    );

    assign word_a = {a_mem_req, a_mem_write, a_iord, a_ir_write, a_pc_en,
                     a_pc_src, a_alu_src_a, a_alu_src_b, a_zero_ext,
                     a_alu_control, a_reg_dst, a_mem_to_reg, a_reg_write,
                     a_illegal_op, a_mem_err};
    assign word_b = {b_mem_req, b_mem_write, b_iord, b_ir_write, b_pc_en,
                     b_pc_src, b_alu_src_a, b_alu_src_b, b_zero_ext,
                     b_alu_control, b_reg_dst, b_mem_to_reg, b_reg_write,
                     b_illegal_op, b_mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [18:0] got,
                            input logic [18:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, check both controllers mid-cycle,
    // then advance to just after the next rising edge.
    task automatic run_cycle(input string tag, input logic rdy,
                             input logic [18:0] exp_a,
                             input logic [18:0] exp_b);
        mem_ready = rdy;
        #2;
        check_eq({tag, "/a"}, word_a, exp_a);
        check_eq({tag, "/b"}, word_b, exp_b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("reset/a", word_a, W_RST);
        check_eq("reset/b", word_b, W_RST);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        opcode    = 6'b100011;
        funct     = 6'b100000;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // lw, zero wait
        opcode = 6'b100011;
        run_cycle("lw fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("lw decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("lw memadr", 1'b1, W_MEMADR,    W_MEMADR);
        run_cycle("lw memrd",  1'b1, W_MEMRD,     W_MEMRD);
        run_cycle("lw memwb",  1'b1, W_MEMWB,     W_MEMWB);

        // sw, three wait cycles in MEMWR
        opcode = 6'b101011;
        run_cycle("sw fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("sw decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("sw memadr", 1'b1, W_MEMADR,    W_MEMADR);
        for (int i = 0; i < 3; i++) begin
            run_cycle("sw memwr wait", 1'b0, W_MEMWR, W_MEMWR);
        end
        run_cycle("sw memwr done", 1'b1, W_MEMWR, W_MEMWR);

        // R-type slt
        opcode = 6'b000000;
        funct  = 6'b101010;
        run_cycle("slt fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("slt decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("slt exec",   1'b1, W_EXEC_SLT,  W_EXEC_SLT);
        run_cycle("slt aluwb",  1'b1, W_ALUWB,     W_ALUWB);

        // R-type with unsupported funct
        funct = 6'b000000;
        run_cycle("badfn fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("badfn decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("badfn exec",   1'b1, W_EXEC_BAD,  W_EXEC_BAD);

        // addi (its fetch also shows the illegal funct returned to FETCH)
        opcode = 6'b001000;
        funct  = 6'b100000;
        run_cycle("addi fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("addi decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("addi exec",   1'b1, W_IMM_ADDI,  W_IMM_ADDI);
        run_cycle("addi immwb",  1'b1, W_IMMWB,     W_IMMWB);

        // beq taken
        opcode   = 6'b000100;
        alu_zero = 1'b1;
        run_cycle("beq fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("beq decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("beq branch", 1'b1, W_BR_TAKEN,  W_BR_TAKEN);
        alu_zero = 1'b0;

        // j
        opcode = 6'b000010;
        run_cycle("j fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("j decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("j jump",   1'b1, W_JUMP,      W_JUMP);
        run_cycle("j next",   1'b1, W_FETCH_RDY, W_FETCH_RDY);

        // bne: illegal on dut_a, branch on dut_b
        do_reset();
        opcode   = 6'b000101;
        alu_zero = 1'b0;
        run_cycle("bne0 fetch",  1'b1, W_FETCH_RDY,  W_FETCH_RDY);
        run_cycle("bne0 decode", 1'b1, W_DECODE_ILL, W_DECODE);
        run_cycle("bne0 branch", 1'b1, W_FETCH_RDY,  W_BR_TAKEN);
        do_reset();
        alu_zero = 1'b1;
        run_cycle("bne1 fetch",  1'b1, W_FETCH_RDY,  W_FETCH_RDY);
        run_cycle("bne1 decode", 1'b1, W_DECODE_ILL, W_DECODE);
        run_cycle("bne1 branch", 1'b1, W_FETCH_RDY,  W_BR_NOT);
        alu_zero = 1'b0;

        // ori / andi
        do_reset();
        opcode = 6'b001101;
        run_cycle("ori fetch",  1'b1, W_FETCH_RDY,  W_FETCH_RDY);
        run_cycle("ori decode", 1'b1, W_DECODE_ILL, W_DECODE);
        run_cycle("ori exec",   1'b1, W_FETCH_RDY,  W_IMM_ORI);
        run_cycle("ori immwb",  1'b1, W_DECODE_ILL, W_IMMWB);
        do_reset();
        opcode = 6'b001100;
        run_cycle("andi fetch",  1'b1, W_FETCH_RDY,  W_FETCH_RDY);
        run_cycle("andi decode", 1'b1, W_DECODE_ILL, W_DECODE);
        run_cycle("andi exec",   1'b1, W_FETCH_RDY,  W_IMM_ANDI);

        // Fetch timeout on dut_b at the fifth stalled cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle("to wait", 1'b0, W_FETCH_WAIT, W_FETCH_WAIT);
        end
        run_cycle("to fire",    1'b0, W_FETCH_WAIT, W_FETCH_TO);
        run_cycle("to restart", 1'b0, W_FETCH_WAIT, W_FETCH_WAIT);
        run_cycle("to resume",  1'b1, W_FETCH_RDY,  W_FETCH_RDY);

        // Reset asserted during MEMRD
        do_reset();
        opcode = 6'b100011;
        run_cycle("rlw fetch",  1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("rlw decode", 1'b1, W_DECODE,    W_DECODE);
        run_cycle("rlw memadr", 1'b1, W_MEMADR,    W_MEMADR);
        mem_ready = 1'b0;
        #2;
        check_eq("rlw memrd/a", word_a, W_MEMRD);
        check_eq("rlw memrd/b", word_b, W_MEMRD);
        rst_n = 1'b0;
        #1;
        check_eq("rlw abort/a", word_a, W_RST);
        check_eq("rlw abort/b", word_b, W_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle("rlw refetch", 1'b1, W_FETCH_RDY, W_FETCH_RDY);
        run_cycle("rlw decode2", 1'b1, W_DECODE,    W_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
